transmitter: RTL
================

Name: transmitter

Overview:
Serial transmit stage that feeds the receive-side deserializer across the S_data link. It accepts one 55-bit packet from the router core through a valid/ready handshake and shifts it out on a single wire. Each packet is one framed serial word: start bit, 55 data bits LSB first, even parity bit, stop bit, then an idle gap. It is the transmit-side counterpart of the receive path on each router port.

Parameters:
CLKS_PER_BIT, 1, Clk_S cycles per serial bit; legal range 1..16.
GAP_BITS, 2, minimum idle-high bit times after each stop bit before the next start bit; legal range 0..15.

Ports:
Clk_S  input  1  serial link clock; all logic on rising edge.
Rst_n  input  1  asynchronous, active-low reset.
TX_Data_Valid  input  1  core presents a packet on TX_Data.
TX_Data  input  55  packet payload; sampled only on the accept edge.
TX_Ready  output  1  block can accept a packet this cycle.
TX_Busy  output  1  frame or gap in progress.
S_data  output  1  serial line, registered, idle high.

Behaviour:
- Reset (Rst_n low, asynchronous): state IDLE, S_data=1, TX_Ready=1, TX_Busy=0, shift register and counters cleared. Reset mid-frame aborts the frame immediately, with S_data forced to 1. No partial frame resumes after reset.
- Accept: rising edge where TX_Data_Valid=1 and TX_Ready=1. TX_Data is captured into a 55-bit shift register on that edge. Even parity (XOR of all 55 bits) is computed from the captured value.
- TX_Ready = (state==IDLE), registered. It drops on the accept edge. TX_Data changes while TX_Ready=0 are ignored. TX_Data_Valid held high across a frame causes no second accept until IDLE is re-entered.
- TX_Busy = not TX_Ready.
- States, each lasting CLKS_PER_BIT cycles per bit:
  - IDLE: S_data=1; go to START on accept.
  - START: S_data=0; one bit time.
  - DATA: S_data = shreg[0]; shift right each bit time; 6-bit index counts 0..54; leave after bit 54.
  - PARITY: S_data = parity bit; one bit time.
  - STOP: S_data=1; one bit time.
  - GAP: S_data=1 for GAP_BITS bit times, then IDLE. If GAP_BITS=0, go STOP -> IDLE directly.
- Timing: let cycle 0 be the first cycle after the accept edge, and C = CLKS_PER_BIT.
  - Start bit occupies cycles 0..C-1.
  - Data bit i occupies cycles C*(1+i) .. C*(2+i)-1.
  - Parity occupies cycles C*56 .. C*57-1.
  - Stop occupies cycles C*57 .. C*58-1.
  - TX_Ready returns high at cycle C*(58+GAP_BITS).
- Throughput: with C=1 and GAP_BITS=2, back-to-back packets start every 61 cycles (60 frame-and-gap cycles plus the accept cycle).
- A bit-time counter (4 bits) reloads at each bit boundary. The data index never exceeds 54. No wrap occurs beyond state sequencing.
- S_data is driven from a flop only, so the line is glitch-free.
- Unreachable state encodings recover to IDLE with S_data=1.

Decomposition:
- Shared package `txrx_pkg` holds:
  - PKT_W=55
  - FRAME_BITS=58
  - state encoding: IDLE, START, DATA, PARITY, STOP, GAP
  - the bit-order and parity convention, shared with the receive-side deserializer so that both ends agree.
- One natural sub-module: `bit_timer`. It is a CLKS_PER_BIT down-counter that outputs a one-cycle `bit_tick` and reloads on `start`.
- FSM, shift register and parity live in the top.

Test Plan:
1. Reset: hold Rst_n=0 with TX_Data_Valid=1 -> S_data=1, TX_Ready=1, TX_Busy=0. Release Rst_n -> accept on the first edge with valid.
2. C=1, GAP=2, TX_Data=55'h1 -> S_data sequence:
   - cycle 0 = 0 (start)
   - cycle 1 = 1 (bit 0)
   - cycles 2..55 = 0
   - cycle 56 = 1 (parity)
   - cycle 57 = 1 (stop)
   - cycles 58..59 = 1 (gap)
   - TX_Ready high at cycle 60.
3. C=1, TX_Data=55'h7F_FFFF_FFFF_FFFF (all 55 ones, odd popcount) -> cycles 1..55 = 1, parity cycle 56 = 1; TX_Data=55'h3 -> parity = 0.
4. C=4, TX_Data=55'h2A -> each bit held exactly 4 cycles; stop bit ends at cycle 231; TX_Ready high at cycle 240.
5. TX_Data_Valid held high, TX_Data changed mid-frame -> only the originally captured value is transmitted. Second accept occurs at cycle 60 (C=1, GAP=2). The next frame's start bit appears at cycle 61.
6. Assert Rst_n=0 at cycle 20 of a frame -> S_data=1 and TX_Ready=1 immediately (asynchronous). New accept after release -> full correct frame. A loopback into the receiver reproduces the packet exactly.

Source files
------------

// File: rtl/txrx_pkg.sv
// Shared serial-link definitions: packet/frame sizes, FSM encoding, bit order and parity.
`default_nettype none

package txrx_pkg;

    localparam int PKT_W      = 55;
    localparam int FRAME_BITS = 58;   // start + PKT_W data + parity + stop

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;

    // Both ends agree: even parity bit is the XOR of every payload bit.
    function automatic logic frame_parity(input logic [PKT_W-1:0] d);
        return ^d;
    endfunction

    // Payload goes out LSB first, so the shifter moves toward bit 0.
    function automatic logic [PKT_W-1:0] shift_out(input logic [PKT_W-1:0] d);
        return {1'b0, d[PKT_W-1:1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/transmitter_bit_timer.sv
// Bit-time down-counter: one-cycle bit_tick every CLKS_PER_BIT cycles while enabled.
`default_nettype none

module bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic Clk_S,
    input  logic Rst_n,
    input  logic start,
    input  logic en,
    output logic bit_tick
);

    localparam logic [3:0] RELOAD = 4'(CLKS_PER_BIT - 1);

    logic [3:0] cnt;

    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt <= 4'd0;
        end else if (start) begin
            cnt <= RELOAD;
        end else if (en) begin
            if (cnt == 4'd0) cnt <= RELOAD;
            else             cnt <= cnt - 4'd1;
        end
    end

    assign bit_tick = en && (cnt == 4'd0);

endmodule

`default_nettype wire

// File: rtl/transmitter.sv
// Framed serial transmitter: start, 55 data bits LSB first, even parity, stop, idle gap.
`default_nettype none

module transmitter
    import txrx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_BITS     = 2
) (
    input  logic             Clk_S,
    input  logic             Rst_n,
    input  logic             TX_Data_Valid,
    input  logic [PKT_W-1:0] TX_Data,
    output logic             TX_Ready,
    output logic             TX_Busy,
    output logic             S_data
);

    localparam logic [5:0] LAST_IDX = 6'(PKT_W - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

    logic [2:0]       state;
    logic [PKT_W-1:0] shreg;
    logic             parity;
    logic [5:0]       idx;
    logic [3:0]       gap_cnt;
    logic             ready_q;
    logic             s_data_q;
    logic             accept;
    logic             bit_tick;

    assign accept = TX_Data_Valid && ready_q;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .Clk_S    (Clk_S),
        .Rst_n    (Rst_n),
        .start    (accept),
        .en       (state != ST_IDLE),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            parity   <= 1'b0;
            idx      <= 6'd0;
            gap_cnt  <= 4'd0;
            ready_q  <= 1'b1;
            s_data_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_START;
                        shreg    <= TX_Data;
                        parity   <= frame_parity(TX_Data);
                        ready_q  <= 1'b0;
                        s_data_q <= 1'b0;
                    end else begin
                        ready_q  <= 1'b1;
                        s_data_q <= 1'b1;
                    end
                end
                ST_START: if (bit_tick) begin
                    state    <= ST_DATA;
                    idx      <= 6'd0;
                    s_data_q <= shreg[0];
                    shreg    <= shift_out(shreg);
                end
                ST_DATA: if (bit_tick) begin
                    if (idx == LAST_IDX) begin
                        state    <= ST_PARITY;
                        s_data_q <= parity;
                    end else begin
                        idx      <= idx + 6'd1;
                        s_data_q <= shreg[0];
                        shreg    <= shift_out(shreg);
                    end
                end
                ST_PARITY: if (bit_tick) begin
                    state    <= ST_STOP;
                    s_data_q <= 1'b1;
                end
                ST_STOP: if (bit_tick) begin
                    s_data_q <= 1'b1;
                    gap_cnt  <= 4'd0;
                    if (GAP_BITS == 0) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: if (bit_tick) begin
                    s_data_q <= 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ready_q  <= 1'b1;
                    s_data_q <= 1'b1;
                end
            endcase
        end
    end

    assign TX_Ready = ready_q;
    assign TX_Busy  = ~ready_q;
    assign S_data   = s_data_q;

endmodule

`default_nettype wire
